countdown_timer: RTL



---
 rtl/countdown_pkg.sv | 37 +++
 rtl/btn_edge.sv | 26 ++
 rtl/countdown_timer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD hh:mm:ss countdown timer.
//   - state_e      : top-level operating mode
//   - Dig*         : digit indices within the 24-bit BCD word (0 = sec_1 ... 5 = hr_10)
//   - digit_max()  : largest legal value of a digit, given the current hr_10 and hour range
package countdown_pkg;

  typedef enum logic [1:0] {
    StSet   = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StAlarm = 2'd3
  } state_e;

  localparam int unsigned NumDigits = 6;
  localparam int unsigned DigSec1   = 0;
  localparam int unsigned DigSec10  = 1;
  localparam int unsigned DigMin1   = 2;
  localparam int unsigned DigMin10  = 3;
  localparam int unsigned DigHr1    = 4;
  localparam int unsigned DigHr10   = 5;

  // hr_1 is limited only when hr_10 sits at its own maximum (e.g. 2x for a 23-hour range).
  function automatic logic [3:0] digit_max(input int unsigned idx, input logic [3:0] hr10,
                                           input int unsigned hours_max);
    logic [3:0] hr10_max;
    logic [3:0] result;
    hr10_max = 4'(hours_max / 10);
    case (idx)
      DigSec10, DigMin10: result = 4'd5;
      DigHr10:            result = hr10_max;
      DigHr1:             result = (hr10 == hr10_max) ? 4'(hours_max % 10) : 4'd9;
      default:            result = 4'd9;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a bundle of already-debounced button levels.
//   clk, reset : clock and asynchronous active-high reset
//   level      : current button levels
//   rise       : one-cycle pulse where level is high and was low on the previous cycle
module btn_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/countdown_timer.sv
// BCD hh:mm:ss countdown timer with cursor digit editing, preset load, pause/resume and a
// timed expiry alarm.
//   clk, reset                      : clock, asynchronous active-high reset
//   up/down/left/right/start/load   : debounced button levels (edge-detected here)
//   preset_bcd                      : {hr_10,hr_1,min_10,min_1,sec_10,sec_1} load source
//   time_bcd                        : remaining time, same packing
//   cursor                          : selected digit, 0 = sec_1 ... 5 = hr_10
//   running / paused / done         : high in RUN / PAUSE / ALARM
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned HOURS_MAX = 23,
  parameter int unsigned ALARM_SEC = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        start,
  input  logic        load,
  input  logic [23:0] preset_bcd,
  output logic [23:0] time_bcd,
  output logic [2:0]  cursor,
  output logic        running,
  output logic        paused,
  output logic        done
);

  localparam int unsigned PrescW      = $clog2(CLK_HZ);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_HZ - 1);
  localparam int unsigned AlarmCycles = ALARM_SEC * CLK_HZ;
  localparam int unsigned AlarmW      = $clog2(AlarmCycles);
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(AlarmCycles - 1);

  state_e             state_q, state_d;
  logic [23:0]        time_q, time_d;
  logic [23:0]        saved_q, saved_d;
  logic [2:0]         cursor_q, cursor_d;
  logic [PrescW-1:0]  presc_q, presc_d;
  logic [AlarmW-1:0]  alarm_q, alarm_d;

  logic [5:0] rise;
  logic       rise_start, rise_load, rise_left, rise_right, rise_up, rise_down;

  btn_edge #(
    .WIDTH(6)
  ) u_btn_edge (
    .clk  (clk),
    .reset(reset),
    .level({start, load, left, right, up, down}),
    .rise (rise)
  );

  assign rise_start = rise[5];
  assign rise_load  = rise[4];
  assign rise_left  = rise[3];
  assign rise_right = rise[2];
  assign rise_up    = rise[1];
  assign rise_down  = rise[0];

  // Cursor digit edit: +1/-1 with wrap, then re-clamp hr_1 in case hr_10 moved.
  logic [3:0]  cur_dig, cur_max, edit_val, hr1_max;
  logic [23:0] edit_time;

  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < NumDigits; i++) begin
      if (cursor_q == 3'(i)) cur_dig = time_q[4*i +: 4];
    end
    cur_max = digit_max(32'(cursor_q), time_q[23:20], HOURS_MAX);
    if (rise_up) begin
      edit_val = (cur_dig >= cur_max) ? 4'd0 : cur_dig + 4'd1;
    end else begin
      edit_val = (cur_dig == 4'd0 || cur_dig > cur_max) ? cur_max : cur_dig - 4'd1;
    end
    edit_time = time_q;
    for (int i = 0; i < NumDigits; i++) begin
      if (cursor_q == 3'(i)) edit_time[4*i +: 4] = edit_val;
    end
    hr1_max = digit_max(DigHr1, edit_time[23:20], HOURS_MAX);
    if (edit_time[19:16] > hr1_max) edit_time[19:16] = hr1_max;
  end

  // Preset load: clamp hr_10 first so the hr_1 limit is taken against the clamped value.
  logic [3:0]  load_hr10_max, load_hr10, load_lim;
  logic [23:0] load_time;

  always_comb begin
    load_hr10_max = digit_max(DigHr10, 4'd0, HOURS_MAX);
    load_hr10 = (preset_bcd[23:20] > load_hr10_max) ? load_hr10_max : preset_bcd[23:20];
    load_lim  = 4'd0;
    load_time = '0;
    for (int i = 0; i < NumDigits; i++) begin
      load_lim = digit_max(i, load_hr10, HOURS_MAX);
      load_time[4*i +: 4] = (preset_bcd[4*i +: 4] > load_lim) ? load_lim : preset_bcd[4*i +: 4];
    end
  end

  // One-second BCD borrow chain; borrowing digits reload to 9 (units) or 5 (tens).
  logic [23:0] dec_time;
  logic        dec_borrow;

  always_comb begin
    dec_time   = time_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < NumDigits; i++) begin
      if (dec_borrow) begin
        if (dec_time[4*i +: 4] == 4'd0) begin
          dec_time[4*i +: 4] = (i % 2 == 1) ? 4'd5 : 4'd9;
        end else begin
          dec_time[4*i +: 4] = dec_time[4*i +: 4] - 4'd1;
          dec_borrow         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    saved_d  = saved_q;
    cursor_d = cursor_q;
    presc_d  = presc_q;
    alarm_d  = alarm_q;
    unique case (state_q)
      StSet: begin
        if (rise_start) begin
          if (time_q != 24'd0) begin
            saved_d = time_q;
            presc_d = '0;
            state_d = StRun;
          end
        end else if (rise_load) begin
          time_d = load_time;
        end else if (rise_left) begin
          cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
        end else if (rise_right) begin
          cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
        end else if (rise_up || rise_down) begin
          time_d = edit_time;
        end
      end
      StRun: begin
        if (rise_start) begin
          state_d = StPause;
        end else if (presc_q == PrescLast) begin
          presc_d = '0;
          if (time_q != 24'd0) begin
            time_d = dec_time;
            if (dec_time == 24'd0) begin
              state_d = StAlarm;
              alarm_d = '0;
            end
          end
        end else begin
          presc_d = presc_q + PrescW'(1);
        end
      end
      StPause: begin
        // A load rise outranks left/right, so it masks them even though load does nothing here.
        if (rise_start) begin
          state_d = StRun;
        end else if (!rise_load && (rise_left || rise_right)) begin
          state_d = StSet;
          presc_d = '0;
        end
      end
      StAlarm: begin
        if ((|rise) || alarm_q == AlarmLast) begin
          state_d  = StSet;
          time_d   = saved_q;
          cursor_d = 3'd0;
          presc_d  = '0;
          alarm_d  = '0;
        end else begin
          alarm_d = alarm_q + AlarmW'(1);
        end
      end
      default: state_d = StSet;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StSet;
      time_q   <= '0;
      saved_q  <= '0;
      cursor_q <= '0;
      presc_q  <= '0;
      alarm_q  <= '0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      saved_q  <= saved_d;
      cursor_q <= cursor_d;
      presc_q  <= presc_d;
      alarm_q  <= alarm_d;
    end
  end

  assign time_bcd = time_q;
  assign cursor   = cursor_q;
  assign running  = (state_q == StRun);
  assign paused   = (state_q == StPause);
  assign done     = (state_q == StAlarm);

endmodule
